arb_out_queue: RTL

Decoupling queue directly downstream of the 4-input round-robin arbiter. It captures each granted transfer, meaning the 8-bit payload plus its 2-bit source index (`io_chosen`), into a small FIFO. It presents those transfers to the consumer with ready/valid handshaking and reports per-source occupancy for fairness monitoring. It isolates the arbiter's combinational `io_out_ready` path from the consumer.

---
 rtl/arb_out_queue.sv | 118 +++++++++++
 1 files changed

// File: rtl/arb_out_queue.sv
// Output queue behind the 4-input round-robin arbiter: FIFO of {chosen, bits} with per-source occupancy.
// Optional zero-latency flow-through when empty: define ARB_OUT_QUEUE_FLOW_EN.
module arb_out_queue_src_cnt #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] cnt
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)             cnt <= '0;
    else if (inc && !dec)   cnt <= cnt + CW'(1);
    else if (dec && !inc)   cnt <= cnt - CW'(1);
  end
endmodule

module arb_out_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_enq_valid,
  output logic             io_enq_ready,
  input  logic [WIDTH-1:0] io_enq_bits,
  input  logic [1:0]       io_enq_chosen,
  output logic             io_deq_valid,
  input  logic             io_deq_ready,
  output logic [WIDTH-1:0] io_deq_bits,
  output logic [1:0]       io_deq_chosen,
  output logic [CW-1:0]    io_count,
  output logic [CW-1:0]    io_src_count_0,
  output logic [CW-1:0]    io_src_count_1,
  output logic [CW-1:0]    io_src_count_2,
  output logic [CW-1:0]    io_src_count_3
);
  typedef struct packed {
    logic [1:0]       chosen;
    logic [WIDTH-1:0] bits;
  } entry_t;

  entry_t [DEPTH-1:0] mem;
  entry_t             head_e;
  logic [PW-1:0]      head, tail;
  logic [CW-1:0]      count;
  logic               empty, full, bypass, enq_fire, deq_fire;
  logic [3:0]         src_inc, src_dec;
  logic [3:0][CW-1:0] src_cnt;

  assign head_e       = mem[head];
  assign empty        = (count == '0);
  assign full         = (count == CW'(DEPTH));
  assign io_enq_ready = !full;

`ifdef ARB_OUT_QUEUE_FLOW_EN
  // Empty queue forwards the enq side straight through; storage is skipped only if consumed now.
  assign bypass        = empty && io_enq_valid && io_deq_ready;
  assign io_deq_valid  = !empty || io_enq_valid;
  assign io_deq_bits   = empty ? io_enq_bits   : head_e.bits;
  assign io_deq_chosen = empty ? io_enq_chosen : head_e.chosen;
`else
  assign bypass        = 1'b0;
  assign io_deq_valid  = !empty;
  assign io_deq_bits   = head_e.bits;
  assign io_deq_chosen = head_e.chosen;
`endif

  assign enq_fire = io_enq_valid && !full && !bypass;
  assign deq_fire = io_deq_valid && io_deq_ready && !bypass;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem   <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq_fire) begin
        mem[tail] <= '{chosen: io_enq_chosen, bits: io_enq_bits};
        tail      <= tail + PW'(1);
      end
      if (deq_fire) head <= head + PW'(1);
      case ({enq_fire, deq_fire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    src_inc = '0;
    src_dec = '0;
    for (int s = 0; s < 4; s++) begin
      src_inc[s] = enq_fire && (io_enq_chosen == 2'(s));
      src_dec[s] = deq_fire && (head_e.chosen == 2'(s));
    end
  end

  // Same-source enq+deq cancels inside each counter.
  arb_out_queue_src_cnt #(.CW(CW)) u_src [3:0] (
    .clk   (clk),
    .reset (reset),
    .inc   (src_inc),
    .dec   (src_dec),
    .cnt   (src_cnt)
  );

  assign io_count       = count;
  assign io_src_count_0 = src_cnt[0];
  assign io_src_count_1 = src_cnt[1];
  assign io_src_count_2 = src_cnt[2];
  assign io_src_count_3 = src_cnt[3];
endmodule
